// File: rtl/regfile_mp.sv
// Multi-port register file: NRD registered read ports, one lane-masked write port,
// write-through bypass, optional hardwired r0, and a one-register-per-cycle clear sweep.
module regfile_mp #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 4,
    parameter int unsigned NRD     = 3,
    parameter int unsigned LW      = 16,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW/LW-1:0]  wr_mask,
    input  logic [DW-1:0]     wr_data,
    input  logic              clr_req,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned NL    = DW / LW;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] mem_q  [DEPTH];
    logic [DW-1:0] mem_d  [DEPTH];
    logic [DW-1:0] rdat_q [NRD];
    logic [DW-1:0] rdat_d [NRD];
    logic [AW-1:0] raddr  [NRD];

    logic          accept;
    logic          wr_ok;
    logic [DW-1:0] bit_mask;
    logic [DW-1:0] wr_merged;

    // Slice the flat read address bus and publish the read data registers.
    for (genvar p = 0; p < NRD; p++) begin : g_port
        assign raddr[p]             = rd_addr[p*AW +: AW];
        assign rd_data[p*DW +: DW]  = rdat_q[p];
    end

    // Requests are honoured only while idle and not pre-empted by a clear request.
    assign accept = (state_q == IDLE) && !clr_req;
    assign wr_ok  = accept && wr_en && !(ZERO_R0 && (wr_addr == '0));
    assign busy   = (state_q == CLEAR);

    // Expand the lane mask into a per-bit mask.
    always_comb begin
        bit_mask = '0;
        for (int k = 0; k < NL; k++) begin
            bit_mask[k*LW +: LW] = {LW{wr_mask[k]}};
        end
    end

    // Post-write value of the addressed register; also feeds the bypass path.
    assign wr_merged = (mem_q[wr_addr] & ~bit_mask) | (wr_data & bit_mask);

    // Clear sequencer next state and sweep counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Array next state: masked write when idle, one register zeroed per sweep cycle.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            mem_d[r] = mem_q[r];
        end
        if (wr_ok) begin
            mem_d[wr_addr] = wr_merged;
        end
        if (state_q == CLEAR) begin
            mem_d[cnt_q] = '0;
        end
    end

    // Read data next state: hold unless enabled; bypass same-cycle writes.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rdat_d[p] = rdat_q[p];
            if (accept && rd_en[p]) begin
                if (ZERO_R0 && (raddr[p] == '0)) begin
                    rdat_d[p] = '0;
                end else if (wr_ok && (raddr[p] == wr_addr)) begin
                    rdat_d[p] = wr_merged;
                end else begin
                    rdat_d[p] = mem_q[raddr[p]];
                end
            end
        end
    end

    // Sequencer state and sweep counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register array storage; reset zeroes every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    // Registered read data for every port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NRD; p++) begin
                rdat_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NRD; p++) begin
                rdat_q[p] <= rdat_d[p];
            end
        end
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DW, default 32: data word width in bits; SHALL be a multiple of LW.
REQ-002 Parameter AW, default 4: address width; register count DEPTH = 2**AW.
REQ-003 Parameter NRD, default 3: number of independent read ports.
REQ-004 Parameter LW, default 16: write lane width in bits; NL = DW/LW lanes.
REQ-005 Parameter ZERO_R0, default 0: when 1, register 0 SHALL be hardwired to zero.
REQ-006 Port list (clock and reset first):
 - clk  in  1  single clock; all state updates on its rising edge.
 - reset  in  1  asynchronous, active-low reset.
 - rd_en  in  NRD  per-port read enable; bit p controls port p.
 - rd_addr  in  NRD*AW  read addresses; port p occupies bits [p*AW +: AW].
 - rd_data  out  NRD*DW  registered read data; port p occupies bits [p*DW +: DW].
 - wr_en  in  1  write enable.
 - wr_addr  in  AW  write address.
 - wr_mask  in  NL  lane write mask; bit k covers bits [k*LW +: LW].
 - wr_data  in  DW  write data.
 - clr_req  in  1  one-cycle request to clear the whole array.
 - busy  out  1  high while a clear sweep runs.

Function
REQ-007 Reads and writes SHALL be accepted in the same cycle; no mutual exclusion between read and write.
REQ-008 Read latency SHALL be 1 cycle: rd_en[p]=1 at edge N loads rd_data port p at edge N with the value of register rd_addr[p]; it is visible after that edge.
REQ-009 With rd_en[p]=0, rd_data port p SHALL hold its previous value.
REQ-010 With wr_en=1, each lane k where wr_mask[k]=1 SHALL be written from wr_data; lanes with wr_mask[k]=0 SHALL keep their old contents.
REQ-011 wr_en=1 with wr_mask all-zero SHALL leave the array unchanged.
REQ-012 Write-through bypass: when a read port and the write port address the same register in the same cycle, that port SHALL return the merged post-write value, i.e. new lanes where masked and old lanes elsewhere.
REQ-013 Any number of read ports SHALL be able to address the same register simultaneously, each receiving the identical value.
REQ-014 With ZERO_R0=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0, including on the bypass path.
REQ-015 The clear sequencer SHALL have two states, IDLE and CLEAR.
REQ-016 IDLE->CLEAR SHALL occur on clr_req=1 at a rising edge; at that edge the sweep counter loads 0 and busy rises.
REQ-017 In CLEAR, one register per cycle SHALL be zeroed at counter address 0..DEPTH-1, taking DEPTH cycles in total.
REQ-018 CLEAR->IDLE SHALL occur on the edge that clears address DEPTH-1; busy falls at that same edge.
REQ-019 While busy=1, wr_en, rd_en and clr_req SHALL be ignored, and rd_data SHALL hold its value.
REQ-020 In IDLE, a clr_req coinciding with wr_en/rd_en SHALL take priority: the write is dropped and rd_data holds.
REQ-021 The sweep counter SHALL be AW bits wide; termination SHALL be detected at DEPTH-1 with no dependence on wrap-around.

Reset
REQ-022 While reset=0, asynchronously: all DEPTH registers SHALL be 0, rd_data all 0, busy 0, state IDLE, sweep counter 0.
REQ-023 Reset asserted mid-sweep SHALL abort the sweep to IDLE with the array zeroed.
REQ-024 The first functional edge after reset deasserts SHALL accept normal operation.

Verification
REQ-025 Write/readback: write 0xDEADBEEF to r5 (mask 2'b11), next cycle read r5 on port 0 -> rd_data0 = 0xDEADBEEF one cycle later.
REQ-026 Lane mask: r3 = 0x11112222; write 0xAAAABBBB with mask 2'b10 -> r3 reads 0xAAAA2222; with mask 2'b00 -> still 0xAAAA2222.
REQ-027 Bypass: same cycle write r7 = 0x12345678 (mask 2'b01, old 0xFFFF0000) and read r7 on all 3 ports -> all ports = 0xFFFF5678.
REQ-028 Clear: fill r0..r15 nonzero, pulse clr_req -> busy high exactly 16 cycles; a write during busy is dropped; afterwards every register reads 0.
REQ-029 ZERO_R0=1: write 0xFFFFFFFF to r0 -> r0 reads 0, including when the read and write are in the same cycle.
REQ-030 Async reset: assert reset=0 between clock edges at clear-sweep step 8 -> rd_data 0, busy 0 immediately; all registers read 0 after reset is released.
